// File: rtl/acoustics_cmd_pkg.sv
// Shared definitions for the acoustics serial command path:
// opcodes, sync nibble default and state encodings.
package acoustics_cmd_pkg;

    localparam logic [3:0] OP_SET_FREQ         = 4'hF;
    localparam logic [3:0] OP_SET_THRESH       = 4'h7;
    localparam logic [3:0] OP_SEND_MAX         = 4'h4;
    localparam logic [3:0] OP_TRIG_DETECT      = 4'hD;
    localparam logic [3:0] SYNC_NIBBLE_DEFAULT = 4'hA;

    typedef enum logic [1:0] {
        WAIT_CMD,
        WAIT_ARG_HI,
        WAIT_ARG_LO
    } frame_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_e;

    // Opcodes that are followed by a two-byte big-endian argument.
    function automatic logic op_has_arg(input logic [3:0] op);
        return (op == OP_SET_FREQ) || (op == OP_SET_THRESH);
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-FF synchronizer plus mid-bit sampling state machine.
// Strobe/error are asserted in the cycle of the stop-bit sample.
module uart_rx_byte
    import acoustics_cmd_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       rx_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_o,
    output logic       byte_err_o,
    output logic       busy_o,
    output logic       idle_o
);

    localparam int unsigned CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    logic          sync1_q;
    logic          sync2_q;
    rx_state_e     state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            case (state_q)
                RX_IDLE: begin
                    cnt_q <= '0;
                    bit_q <= '0;
                    if (!sync2_q) begin
                        state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q   <= '0;
                        // A line that is high again at mid start bit was a glitch.
                        state_q <= sync2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q   <= '0;
                        shift_q <= {sync2_q, shift_q[7:1]};
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == 3'd7) begin
                            state_q <= RX_STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= sync2_q ? RX_IDLE : RX_BREAK;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RX_BREAK: begin
                    if (sync2_q) begin
                        state_q <= RX_IDLE;
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    assign byte_valid_o = (state_q == RX_STOP) && (cnt_q == BIT_LAST) && sync2_q;
    assign byte_err_o   = (state_q == RX_STOP) && (cnt_q == BIT_LAST) && !sync2_q;
    assign byte_o       = shift_q;
    assign busy_o       = (state_q == RX_START) || (state_q == RX_DATA) || (state_q == RX_STOP);
    assign idle_o       = (state_q == RX_IDLE);

endmodule

// File: rtl/uart_cmd_rx.sv
// Serial command front end: assembles UART bytes into opcode/argument frames
// with an inter-byte timeout; Command/Arg commit atomically with Rx_Ready.
module uart_cmd_rx
    import acoustics_cmd_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT     = 868,
    parameter logic [3:0]  SYNC_NIBBLE      = SYNC_NIBBLE_DEFAULT,
    parameter int unsigned ARG_TIMEOUT_CLKS = 2_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RsRx,
    output logic        Rx_Ready,
    output logic [3:0]  Command,
    output logic [15:0] Arg,
    output logic        Frame_Error,
    output logic        Busy
);

    localparam int unsigned TW = (ARG_TIMEOUT_CLKS > 2) ? $clog2(ARG_TIMEOUT_CLKS) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(ARG_TIMEOUT_CLKS - 1);

    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       rx_err;
    logic       rx_busy;
    logic       rx_idle;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx_byte (
        .clk_i       (clk),
        .reset_i     (reset),
        .rx_i        (RsRx),
        .byte_valid_o(rx_valid),
        .byte_o      (rx_byte),
        .byte_err_o  (rx_err),
        .busy_o      (rx_busy),
        .idle_o      (rx_idle)
    );

    frame_state_e  frame_q;
    logic [3:0]    op_q;
    logic [7:0]    arg_hi_q;
    logic [TW-1:0] to_cnt_q;
    logic          rx_ready_q;
    logic          frame_err_q;
    logic [3:0]    command_q;
    logic [15:0]   arg_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_q     <= WAIT_CMD;
            op_q        <= '0;
            arg_hi_q    <= '0;
            to_cnt_q    <= '0;
            rx_ready_q  <= 1'b0;
            frame_err_q <= 1'b0;
            command_q   <= '0;
            arg_q       <= '0;
        end else begin
            rx_ready_q  <= 1'b0;
            frame_err_q <= 1'b0;
            // Priority: byte error, then byte strobe (which also beats a timeout).
            if (rx_err) begin
                frame_err_q <= 1'b1;
                frame_q     <= WAIT_CMD;
                to_cnt_q    <= '0;
            end else if (rx_valid) begin
                to_cnt_q <= '0;
                case (frame_q)
                    WAIT_CMD: begin
                        if (rx_byte[7:4] != SYNC_NIBBLE) begin
                            frame_err_q <= 1'b1;
                        end else if (op_has_arg(rx_byte[3:0])) begin
                            op_q    <= rx_byte[3:0];
                            frame_q <= WAIT_ARG_HI;
                        end else begin
                            command_q  <= rx_byte[3:0];
                            rx_ready_q <= 1'b1;
                        end
                    end
                    WAIT_ARG_HI: begin
                        arg_hi_q <= rx_byte;
                        frame_q  <= WAIT_ARG_LO;
                    end
                    WAIT_ARG_LO: begin
                        command_q  <= op_q;
                        arg_q      <= {arg_hi_q, rx_byte};
                        rx_ready_q <= 1'b1;
                        frame_q    <= WAIT_CMD;
                    end
                    default: frame_q <= WAIT_CMD;
                endcase
            end else if (frame_q != WAIT_CMD && rx_idle) begin
                if (to_cnt_q == TO_LAST) begin
                    frame_err_q <= 1'b1;
                    frame_q     <= WAIT_CMD;
                    to_cnt_q    <= '0;
                end else begin
                    to_cnt_q <= to_cnt_q + 1'b1;
                end
            end
        end
    end

    assign Rx_Ready    = rx_ready_q;
    assign Frame_Error = frame_err_q;
    assign Command     = command_q;
    assign Arg         = arg_q;
    assign Busy        = (frame_q != WAIT_CMD) || rx_busy;

endmodule

// File: doc/uart_cmd_rx.md
# uart_cmd_rx

Serial command front end for the acoustics FPGA. It receives 8N1 UART bytes on `RsRx` and assembles them into command frames. For each valid frame it presents a 4-bit opcode and an optional 16-bit argument, with a one-cycle `Rx_Ready` pulse. Its outputs feed the command-reader controller directly (`Rx_Ready`, `Command`), and the frequency/threshold registers load from `Arg`.

## Interface
Parameters:
- `CLKS_PER_BIT`, 868: clock cycles per UART bit (100 MHz / 115200).
- `SYNC_NIBBLE`, 4'hA: required upper nibble of every command byte.
- `ARG_TIMEOUT_CLKS`, 2_000_000: maximum idle cycles allowed between bytes of one frame.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `RsRx`  in  1  asynchronous UART line; idles high.
- `Rx_Ready`  out  1  one-cycle pulse; frame complete, `Command`/`Arg` valid.
- `Command`  out  4  opcode of the last good frame.
- `Arg`  out  16  argument of the last frame that carried one.
- `Frame_Error`  out  1  one-cycle pulse; frame discarded.
- `Busy`  out  1  high while a frame is partially received.

## Operation
- All logic uses one clock and a synchronous, active-high reset.
- `RsRx` passes through a 2-FF synchronizer; both flops reset to 1.
- Byte receiver states: `IDLE`, `START`, `DATA`, `STOP`, `BREAK`.
  - `IDLE` → `START` when the synced line is 0.
  - `START`: wait `CLKS_PER_BIT/2` cycles, then sample. If the line is 1, treat it as a glitch and return to `IDLE` with no error. If 0, go to `DATA`.
  - `DATA`: take 8 samples, one every `CLKS_PER_BIT` cycles, LSB first.
  - `STOP`: sample once after `CLKS_PER_BIT` cycles. If 1, issue a byte strobe and go to `IDLE`. If 0, issue a byte error and go to `BREAK`.
  - `BREAK`: wait until the synced line is 1, then go to `IDLE`.
- Frame states: `WAIT_CMD`, `WAIT_ARG_HI`, `WAIT_ARG_LO`.
  - In `WAIT_CMD`, a byte whose `[7:4]` ≠ `SYNC_NIBBLE` pulses `Frame_Error` and the state stays in `WAIT_CMD`.
  - Opcodes 4'hF (set frequency) and 4'h7 (set threshold) take an argument. The opcode is latched internally and the state goes to `WAIT_ARG_HI`.
  - Any other opcode is published immediately and `Rx_Ready` pulses. Unknown opcodes are still published; rejecting them is the consumer's job. `Arg` is unchanged.
  - `WAIT_ARG_HI` latches `Arg[15:8]` and goes to `WAIT_ARG_LO`.
  - `WAIT_ARG_LO` receives `Arg[7:0]`. `Command` and `Arg` update together, `Rx_Ready` pulses, and the state returns to `WAIT_CMD`.
- Inter-byte timeout:
  - In `WAIT_ARG_HI`/`WAIT_ARG_LO`, a counter restarts at each byte strobe and runs while the byte receiver is `IDLE`.
  - If it reaches `ARG_TIMEOUT_CLKS`, `Frame_Error` pulses and the frame state returns to `WAIT_CMD`.
- A byte error (bad stop bit) in any frame state pulses `Frame_Error` and returns the frame state to `WAIT_CMD`.
- `Command` and `Arg` are never partially updated. Argument bytes go into a shadow register; `Arg` commits only when `Rx_Ready` pulses.
- `Busy` is high when the frame state ≠ `WAIT_CMD`, or when the byte receiver is in `START`, `DATA` or `STOP`.

## Timing
- Reset values: `Rx_Ready`=0, `Frame_Error`=0, `Busy`=0, `Command`=4'h0, `Arg`=16'h0. Both state machines go to their first state (`IDLE`/`WAIT_CMD`), and all counters clear.
- Reset mid-byte or mid-frame abandons everything with no error pulse.
- Latency: `Rx_Ready` is registered and asserts on the cycle after the stop-bit sample of the final byte of the frame. `Command`/`Arg` are valid in that same cycle.
- From the `RsRx` falling edge to the final stop sample takes 2 (synchronizer) + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT` cycles, ±1.
- `Rx_Ready` and `Frame_Error` are never high in the same cycle.
- A timeout and a byte strobe in the same cycle resolve in favour of the byte; the counter restarts.
- Back-to-back frames with no idle gap beyond the stop bit are accepted.
- `Command` and `Arg` hold their values until the next `Rx_Ready`.

## Structure
- Shared package `acoustics_cmd_pkg`:
  - Opcode constants: `OP_SET_FREQ`=4'hF, `OP_SET_THRESH`=4'h7, `OP_SEND_MAX`=4'h4, `OP_TRIG_DETECT`=4'hD.
  - `SYNC_NIBBLE` default.
  - Frame-state encoding.
- Sub-module `uart_rx_byte` (synchronizer plus bit state machine). It outputs a byte strobe, the 8-bit byte, a byte error and a busy flag.
- The top level holds the frame state machine, the timeout counter and the output registers.

## Test plan
Simulate with `CLKS_PER_BIT`=16 and `ARG_TIMEOUT_CLKS`=400.
- Send byte 8'hA4 → one `Rx_Ready` pulse, `Command`=4'h4, `Arg`=16'h0000, no `Frame_Error`.
- Send bytes A7, 12, 34 back-to-back → a single `Rx_Ready` after the third stop bit, `Command`=4'h7, `Arg`=16'h1234. `Arg` must not change before that pulse.
- Send AF then 56, then leave the line idle for 500 cycles → `Frame_Error` pulses once, `Arg` stays 16'h1234. A following AD → `Command`=4'hD.
- Send byte 8'h54 (bad sync nibble) → `Frame_Error` pulse, no `Rx_Ready`. Then send a byte with stop bit 0 and the line held low for 100 cycles → one `Frame_Error`, and no start is detected until the line returns high.
- Send a 5-cycle low glitch on `RsRx` → no strobe and no error. Assert `reset` in the middle of an A7/12 frame → all outputs return to their reset values, and a following A4 is decoded normally.
